// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// The instruction-buffer entry layout is defined here so the top and the bench agree on it.
package fetch_unit_pkg;

    localparam int          EXCP_NUM_W       = 16;
    localparam int          ADEF_BIT         = 14;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c00_0000;
    localparam logic [1:0]  SRAM_SIZE_WORD   = 2'b10;

    localparam logic [EXCP_NUM_W-1:0] EXCP_ADEF = EXCP_NUM_W'(1) << ADEF_BIT;

    typedef struct packed {
        logic [31:0]           pc;
        logic [31:0]           inst;
        logic                  excp;
        logic [EXCP_NUM_W-1:0] excp_num;
    } ibuf_entry_t;

    localparam int IBUF_W = $bits(ibuf_entry_t);

endpackage

// File: rtl/fetch_unit_if.sv
// SRAM-like instruction bus between the fetch stage (master) and memory (slave).
interface fetch_unit_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, wdata, addr,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, wdata, addr,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Generic synchronous FIFO (module ifetch_fifo). Head data reads straight from storage,
// so a pushed word is visible the cycle after the push. Clear drops all entries.
module ifetch_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_rd [DEPTH];
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_rd[rd_ptr_q];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~clear_i & ~empty_o;
    assign do_push = push_i & ~clear_i & (~full_o | do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] entry_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                entry_q <= '0;
            end else if (do_push && (wr_ptr_q == PW'(gi))) begin
                entry_q <= din_i;
            end
        end

        assign mem_rd[gi] = entry_q;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: pipelined SRAM-like requests tagged with their PC, a decoupling
// instruction buffer toward decode, and silent discard of responses stranded by a redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int          IBUF_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ds_allowin,
    output logic                  fs_to_ds_valid,
    output logic [31:0]           fs_to_ds_pc,
    output logic [31:0]           fs_to_ds_inst,
    output logic                  fs_to_ds_excp,
    output logic [EXCP_NUM_W-1:0] fs_to_ds_excp_num,
    input  logic                  excp_flush,
    input  logic                  ertn_flush,
    input  logic [31:0]           eentry,
    input  logic [31:0]           era,
    input  logic                  br_taken,
    input  logic [31:0]           br_target,
    fetch_unit_if.master          inst_sram
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int ICW = $clog2(IBUF_DEPTH + 1);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] cancel_q, cancel_d;
    logic          adef_halt_q, adef_halt_d;

    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          credit_ok, fire, resp, keep, adef_push;

    // Outstanding count is exactly the tag-queue occupancy.
    logic [OW-1:0] outstanding;
    logic          tag_full, tag_empty;
    logic [31:0]   tag_pc;

    logic [ICW-1:0] ibuf_count;
    logic           ibuf_full, ibuf_empty, ibuf_push, ibuf_pop;
    ibuf_entry_t    ibuf_din, ibuf_head;

    assign redirect    = excp_flush | ertn_flush | br_taken;
    assign redirect_pc = excp_flush ? eentry : (ertn_flush ? era : br_target);

    // Every accepted request must have an ibuf slot reserved, so responses never overflow it.
    assign credit_ok = (32'(outstanding) + 32'(ibuf_count)) < 32'(IBUF_DEPTH);

    assign inst_sram.req   = !reset && !redirect && !adef_halt_q && (fetch_pc_q[1:0] == 2'b00)
                             && !tag_full && credit_ok;
    assign inst_sram.addr  = fetch_pc_q;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = SRAM_SIZE_WORD;
    assign inst_sram.wstrb = 4'h0;
    assign inst_sram.wdata = 32'h0;

    assign fire = inst_sram.req & inst_sram.addr_ok;
    assign resp = inst_sram.data_ok;
    assign keep = resp && (cancel_q == '0) && !redirect;

    assign adef_push = !reset && !redirect && !adef_halt_q && (fetch_pc_q[1:0] != 2'b00)
                       && (outstanding == cancel_q) && !ibuf_full;

    assign ibuf_push = keep | adef_push;

    always_comb begin
        ibuf_din = '0;
        if (keep) begin
            ibuf_din.pc   = tag_pc;
            ibuf_din.inst = inst_sram.rdata;
        end else begin
            ibuf_din.pc       = fetch_pc_q;
            ibuf_din.excp     = 1'b1;
            ibuf_din.excp_num = EXCP_ADEF;
        end
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        cancel_d    = cancel_q;
        adef_halt_d = adef_halt_q;
        if (redirect) begin
            fetch_pc_d  = redirect_pc;
            cancel_d    = outstanding - OW'(resp);
            adef_halt_d = 1'b0;
        end else begin
            if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
            if (resp && (cancel_q != '0)) cancel_d = cancel_q - 1'b1;
            if (adef_push) adef_halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= RESET_PC;
            cancel_q    <= '0;
            adef_halt_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            cancel_q    <= cancel_d;
            adef_halt_q <= adef_halt_d;
        end
    end

    // Tag queue survives a redirect: the stale responses still arrive and must pop their tags.
    ifetch_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tag_q (
        .clk     (clk),
        .reset   (reset),
        .clear_i (1'b0),
        .push_i  (fire),
        .pop_i   (resp & ~tag_empty),
        .din_i   (inst_sram.addr),
        .dout_o  (tag_pc),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .count_o (outstanding)
    );

    ifetch_fifo #(.WIDTH(IBUF_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk     (clk),
        .reset   (reset),
        .clear_i (redirect),
        .push_i  (ibuf_push),
        .pop_i   (ibuf_pop),
        .din_i   (ibuf_din),
        .dout_o  (ibuf_head),
        .full_o  (ibuf_full),
        .empty_o (ibuf_empty),
        .count_o (ibuf_count)
    );

    assign fs_to_ds_valid    = !ibuf_empty && !redirect && !reset;
    assign ibuf_pop          = fs_to_ds_valid & ds_allowin;
    assign fs_to_ds_pc       = ibuf_head.pc;
    assign fs_to_ds_inst     = ibuf_head.inst;
    assign fs_to_ds_excp     = ibuf_head.excp;
    assign fs_to_ds_excp_num = ibuf_head.excp_num;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable bus responder plus one task per scenario.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allowin = 1'b0;
    logic        excp_flush = 1'b0, ertn_flush = 1'b0, br_taken = 1'b0;
    logic [31:0] eentry = '0, era = '0, br_target = '0;
    logic        fs_to_ds_valid, fs_to_ds_excp;
    logic [31:0] fs_to_ds_pc, fs_to_ds_inst;
    logic [15:0] fs_to_ds_excp_num;

    fetch_unit_if bus ();

    int checks = 0;
    int errors = 0;
    int lat = 1;
    int fire_count = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_pc       (fs_to_ds_pc),
        .fs_to_ds_inst     (fs_to_ds_inst),
        .fs_to_ds_excp     (fs_to_ds_excp),
        .fs_to_ds_excp_num (fs_to_ds_excp_num),
        .excp_flush        (excp_flush),
        .ertn_flush        (ertn_flush),
        .eentry            (eentry),
        .era               (era),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .inst_sram         (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory model: answers each accepted request in order, lat cycles after acceptance.
    initial begin : bus_model
        int cyc;
        logic fired, took;
        logic [31:0] a;
        cyc = 0;
        bus.data_ok = 1'b0;
        bus.rdata = '0;
        forever begin
            @(posedge clk);
            fired = bus.req & bus.addr_ok;
            took  = bus.data_ok;
            a     = bus.addr;
            #1;
            if (reset) begin
                pend_q.delete();
            end else begin
                if (took && pend_q.size() > 0) void'(pend_q.pop_front());
                if (fired) begin
                    pend_q.push_back('{addr: a, due: cyc + lat});
                    fire_count++;
                end
            end
            cyc++;
            if (!reset && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                bus.data_ok = 1'b1;
                bus.rdata   = mem_word(pend_q[0].addr);
            end else begin
                bus.data_ok = 1'b0;
                bus.rdata   = '0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Leaves the bench one tick into cycle 0 after reset; callers drive, wait #1, then sample.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        excp_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
        repeat (2) @(negedge clk);
        fire_count = 0;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.addr_ok = 1'b0;
        ds_allowin = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.req, fs_to_ds_valid} !== 2'b00 || bus.addr !== RPC) begin
            errors++;
            $display("FAIL reset_hold: req=%b valid=%b addr=%h, required req=0 valid=0 addr=%h",
                     bus.req, fs_to_ds_valid, bus.addr, RPC);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== RPC) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h, required req=1 addr=%h", bus.req, bus.addr, RPC);
        end
        checks++;
        if ({fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp, fs_to_ds_excp_num} !== 82'd0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b pc=%h inst=%h excp=%b num=%h, required all zero",
                     fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp, fs_to_ds_excp_num);
        end
        checks++;
        if ({bus.wr, bus.size, bus.wstrb, bus.wdata} !== {1'b0, 2'b10, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL bus_constants: wr=%b size=%b wstrb=%h wdata=%h, required 0/10/0/0",
                     bus.wr, bus.size, bus.wstrb, bus.wdata);
        end
        $display("test_reset done");
    endtask

    task automatic test_streaming();
        bus.addr_ok = 1'b1;
        lat = 1;
        ds_allowin = 1'b1;
        apply_reset();
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin tick(); #1; end
            checks++;
            if (bus.req !== 1'b1 || bus.addr !== RPC + 32'(4 * c)) begin
                errors++;
                $display("FAIL stream_req c%0d: req=%b addr=%h, required req=1 addr=%h",
                         c, bus.req, bus.addr, RPC + 32'(4 * c));
            end
            checks++;
            if (c < 2) begin
                if (fs_to_ds_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early c%0d: valid=%b, required 0", c, fs_to_ds_valid);
                end
            end else if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== RPC + 32'(4 * (c - 2))
                         || fs_to_ds_inst !== mem_word(RPC + 32'(4 * (c - 2))) || fs_to_ds_excp !== 1'b0) begin
                errors++;
                $display("FAIL stream_out c%0d: valid=%b pc=%h inst=%h excp=%b, required 1 %h %h 0",
                         c, fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp,
                         RPC + 32'(4 * (c - 2)), mem_word(RPC + 32'(4 * (c - 2))));
            end
        end
        $display("test_streaming done");
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int got;
        bus.addr_ok = 1'b1;
        lat = 1;
        ds_allowin = 1'b0;
        apply_reset();
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin tick(); #1; end
            checks++;
            if (fire_count > 4) begin
                errors++;
                $display("FAIL bp_credit c%0d: accepted=%0d, required <= 4", c, fire_count);
            end
        end
        checks++;
        if (bus.req !== 1'b0 || fire_count != 4 || fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== RPC) begin
            errors++;
            $display("FAIL bp_full: req=%b accepted=%0d valid=%b pc=%h, required 0 4 1 %h",
                     bus.req, fire_count, fs_to_ds_valid, fs_to_ds_pc, RPC);
        end
        exp_pc = RPC;
        got = 0;
        for (int c = 20; c < 40; c++) begin
            tick();
            ds_allowin = 1'b1;
            #1;
            if (fs_to_ds_valid === 1'b1) begin
                checks++;
                if (fs_to_ds_pc !== exp_pc || fs_to_ds_inst !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL bp_order c%0d: pc=%h inst=%h, required %h %h",
                             c, fs_to_ds_pc, fs_to_ds_inst, exp_pc, mem_word(exp_pc));
                end
                exp_pc += 32'd4;
                got++;
            end
        end
        checks++;
        if (got != 20) begin
            errors++;
            $display("FAIL bp_drain: delivered=%0d, required 20", got);
        end
        $display("test_backpressure done");
    endtask

    task automatic test_cancel();
        bit found;
        bus.addr_ok = 1'b1;
        lat = 3;
        ds_allowin = 1'b1;
        apply_reset();
        tick();
        tick();
        br_taken = 1'b1;
        br_target = 32'h1c00_0100;
        #1;
        checks++;
        if ({bus.req, fs_to_ds_valid} !== 2'b00) begin
            errors++;
            $display("FAIL cancel_redirect_cycle: req=%b valid=%b, required 0 0", bus.req, fs_to_ds_valid);
        end
        tick();
        br_taken = 1'b0;
        #1;
        checks++;
        if (bus.addr !== 32'h1c00_0100) begin
            errors++;
            $display("FAIL cancel_addr: addr=%h, required 1c000100", bus.addr);
        end
        found = 1'b0;
        for (int c = 3; c <= 20 && !found; c++) begin
            if (c > 3) begin tick(); #1; end
            if (fs_to_ds_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (fs_to_ds_pc !== 32'h1c00_0100 || fs_to_ds_inst !== mem_word(32'h1c00_0100) || c != 8) begin
                    errors++;
                    $display("FAIL cancel_first_out: pc=%h inst=%h cycle=%0d, required 1c000100 %h 8",
                             fs_to_ds_pc, fs_to_ds_inst, c, mem_word(32'h1c00_0100));
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL cancel_timeout: valid=0 for 18 cycles, required an entry");
        end
        $display("test_cancel done");
    endtask

    task automatic test_priority();
        bus.addr_ok = 1'b0;
        lat = 1;
        ds_allowin = 1'b1;
        apply_reset();
        excp_flush = 1'b1; ertn_flush = 1'b1; br_taken = 1'b1;
        eentry = 32'h1c00_8000; era = 32'h1c00_a000; br_target = 32'h1c00_c000;
        #1;
        checks++;
        if (bus.req !== 1'b0) begin
            errors++;
            $display("FAIL prio_req_low: req=%b, required 0", bus.req);
        end
        tick();
        excp_flush = 1'b0;
        #1;
        checks++;
        if (bus.addr !== 32'h1c00_8000) begin
            errors++;
            $display("FAIL prio_excp: addr=%h, required 1c008000", bus.addr);
        end
        tick();
        ertn_flush = 1'b0; br_taken = 1'b0;
        #1;
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h1c00_a000) begin
            errors++;
            $display("FAIL prio_ertn: req=%b addr=%h, required 1 1c00a000", bus.req, bus.addr);
        end
        $display("test_priority done");
    endtask

    task automatic test_adef();
        bus.addr_ok = 1'b0;
        lat = 1;
        ds_allowin = 1'b1;
        apply_reset();
        br_taken = 1'b1;
        br_target = 32'h1c00_0102;
        tick();
        br_taken = 1'b0;
        bus.addr_ok = 1'b1;
        #1;
        checks++;
        if (bus.req !== 1'b0 || bus.addr !== 32'h1c00_0102 || fs_to_ds_valid !== 1'b0) begin
            errors++;
            $display("FAIL adef_noreq: req=%b addr=%h valid=%b, required 0 1c000102 0",
                     bus.req, bus.addr, fs_to_ds_valid);
        end
        tick(); #1;
        checks++;
        if ({fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp, fs_to_ds_excp_num}
            !== {1'b1, 32'h1c00_0102, 32'h0, 1'b1, 16'h4000}) begin
            errors++;
            $display("FAIL adef_entry: valid=%b pc=%h inst=%h excp=%b num=%h, required 1 1c000102 0 1 4000",
                     fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_excp, fs_to_ds_excp_num);
        end
        for (int c = 3; c < 8; c++) begin
            tick(); #1;
            checks++;
            if ({bus.req, fs_to_ds_valid} !== 2'b00) begin
                errors++;
                $display("FAIL adef_halt c%0d: req=%b valid=%b, required 0 0", c, bus.req, fs_to_ds_valid);
            end
        end
        tick();
        ertn_flush = 1'b1;
        era = 32'h1c00_0010;
        tick();
        ertn_flush = 1'b0;
        #1;
        checks++;
        if (bus.req !== 1'b1 || bus.addr !== 32'h1c00_0010) begin
            errors++;
            $display("FAIL adef_resume: req=%b addr=%h, required 1 1c000010", bus.req, bus.addr);
        end
        tick(); tick(); #1;
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== 32'h1c00_0010 || fs_to_ds_excp !== 1'b0
            || fs_to_ds_inst !== mem_word(32'h1c00_0010)) begin
            errors++;
            $display("FAIL adef_after: valid=%b pc=%h excp=%b inst=%h, required 1 1c000010 0 %h",
                     fs_to_ds_valid, fs_to_ds_pc, fs_to_ds_excp, fs_to_ds_inst, mem_word(32'h1c00_0010));
        end
        $display("test_adef done");
    endtask

    task automatic test_reset_midflight();
        bus.addr_ok = 1'b1;
        lat = 2;
        ds_allowin = 1'b0;
        apply_reset();
        repeat (5) tick();
        checks++;
        if (fire_count != 4 || fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== RPC) begin
            errors++;
            $display("FAIL mid_setup: accepted=%0d valid=%b pc=%h, required 4 1 %h",
                     fire_count, fs_to_ds_valid, fs_to_ds_pc, RPC);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.req, fs_to_ds_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_in_reset: req=%b valid=%b, required 0 0", bus.req, fs_to_ds_valid);
        end
        tick();
        tick();
        reset = 1'b0;
        lat = 1;
        ds_allowin = 1'b1;
        #1;
        checks++;
        if (fs_to_ds_valid !== 1'b0 || bus.req !== 1'b1 || bus.addr !== RPC) begin
            errors++;
            $display("FAIL mid_after: valid=%b req=%b addr=%h, required 0 1 %h",
                     fs_to_ds_valid, bus.req, bus.addr, RPC);
        end
        for (int c = 1; c < 4; c++) begin
            tick(); #1;
            if (c >= 2) begin
                checks++;
                if (fs_to_ds_valid !== 1'b1 || fs_to_ds_pc !== RPC + 32'(4 * (c - 2))) begin
                    errors++;
                    $display("FAIL mid_restart c%0d: valid=%b pc=%h, required 1 %h",
                             c, fs_to_ds_valid, fs_to_ds_pc, RPC + 32'(4 * (c - 2)));
                end
            end
        end
        $display("test_reset_midflight done");
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bus.addr_ok = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_cancel();
        test_priority();
        test_adef();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
